// File: rtl/io_input_pkg.sv
// Field offsets of the packed word handed to the input-peripheral bank.
package io_input_pkg;

  localparam int DATA_W       = 32;
  localparam int SW_LSB       = 0;
  localparam int BTN_LVL_LSB  = 20;
  localparam int BTN_FLAG_LSB = 24;

endpackage

// File: rtl/io_input_conditioner_debounce_cell.sv
// One raw input bit: two-flop synchroniser, tick-sampled history and
// debounced output flop. RST_LVL is the idle level of the pin, so that a
// cell leaving reset does not see a false transition.
module debounce_cell #(
  parameter int   STABLE_SAMPLES = 4,
  parameter logic RST_LVL        = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick,
  input  logic raw,
  output logic level
);

  logic                      sync_q1;
  logic                      sync_q2;
  logic [STABLE_SAMPLES-1:0] hist;
  logic [STABLE_SAMPLES-1:0] hist_next;

  assign hist_next = {hist[STABLE_SAMPLES-2:0], sync_q2};

  // Two back-to-back flops, nothing in between, to resolve metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= RST_LVL;
      sync_q2 <= RST_LVL;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // On each tick shift in a sample; the output only moves on a unanimous history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist  <= {STABLE_SAMPLES{RST_LVL}};
      level <= RST_LVL;
    end else if (tick) begin
      hist <= hist_next;
      if (&hist_next) begin
        level <= 1'b1;
      end else if (~|hist_next) begin
        level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw switches and active-low push-buttons into the 32-bit word
// read by the input-peripheral bank: debounced levels plus sticky press flags.
module io_input_conditioner
  import io_input_pkg::*;
#(
  parameter int SW_WIDTH       = 18,
  parameter int BTN_WIDTH      = 4,
  parameter int TICK_DIV       = 125000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [SW_WIDTH-1:0]  io_sw_i,
  input  logic [BTN_WIDTH-1:0] io_btn_i,
  input  logic [BTN_WIDTH-1:0] flag_clr_i,
  output logic [DATA_W-1:0]    sw_data_o,
  output logic [BTN_WIDTH-1:0] btn_press_o
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]     tick_cnt;
  logic                 tick;
  logic [SW_WIDTH-1:0]  sw_deb;
  logic [BTN_WIDTH-1:0] btn_lvl;
  logic [BTN_WIDTH-1:0] pressed;
  logic [BTN_WIDTH-1:0] pressed_q;
  logic [BTN_WIDTH-1:0] rise;
  logic [BTN_WIDTH-1:0] flag;
  logic [BTN_WIDTH-1:0] flag_next;
  logic [DATA_W-1:0]    word;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Shared sample tick: free-running 0..TICK_DIV-1, wrapping on the tick edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .RST_LVL        (1'b0)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick   (tick),
      .raw    (io_sw_i[i]),
      .level  (sw_deb[i])
    );
  end

  // Buttons idle high, so their cells reset to 1 and are inverted afterwards.
  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .RST_LVL        (1'b1)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick   (tick),
      .raw    (io_btn_i[i]),
      .level  (btn_lvl[i])
    );
  end

  assign pressed   = ~btn_lvl;
  assign rise      = pressed & ~pressed_q;
  // A new press outranks a simultaneous clear.
  assign flag_next = rise | (flag & ~flag_clr_i);

  // Press edge detection, one-cycle press pulse and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pressed_q   <= '0;
      btn_press_o <= '0;
      flag        <= '0;
    end else begin
      pressed_q   <= pressed;
      btn_press_o <= rise;
      flag        <= flag_next;
    end
  end

  // Assemble the output word; flags are taken from their next value so the
  // word always agrees with the press pulse issued on the same edge.
  always_comb begin
    word                                = '0;
    word[SW_LSB +: SW_WIDTH]            = sw_deb;
    word[BTN_LVL_LSB +: BTN_WIDTH]      = pressed;
    word[BTN_FLAG_LSB +: BTN_WIDTH]     = flag_next;
  end

  // Whole word registered at once so the reader never sees a partial update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_data_o <= '0;
    end else begin
      sw_data_o <= word;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

  localparam int SW_W  = 18;
  localparam int BTN_W = 4;
  localparam int TDIV  = 4;
  localparam int NS    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SW_W-1:0]   sw;
  logic [BTN_W-1:0]  btn;
  logic [BTN_W-1:0]  clr;
  logic [31:0]       data;
  logic [BTN_W-1:0]  press;

  int total = 0;
  int bad   = 0;
  logic [BTN_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  io_input_conditioner #(
    .SW_WIDTH       (SW_W),
    .BTN_WIDTH      (BTN_W),
    .TICK_DIV       (TDIV),
    .STABLE_SAMPLES (NS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .io_sw_i     (sw),
    .io_btn_i    (btn),
    .flag_clr_i  (clr),
    .sw_data_o   (data),
    .btn_press_o (press)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int budget, output logic [BTN_W-1:0] seen, output bit got);
    got  = 1'b0;
    seen = '0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (press != '0) begin
        got  = 1'b1;
        seen = press;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw = '0; btn = '1; clr = '0;
    repeat (3) step();
    total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want %h", data, 32'h0); end
    total++; if (press !== 4'h0) begin bad++; $display("FAIL reset_press: got %h want %h", press, 4'h0); end
    @(negedge clk); rst_n = 1'b1;
    step();
    total++; if (data !== 32'h0) begin bad++; $display("FAIL first_cycle_data: got %h want %h", data, 32'h0); end
    total++; if (press !== 4'h0) begin bad++; $display("FAIL first_cycle_press: got %h want %h", press, 4'h0); end
  endtask

  task automatic test_reset_midrun();
    bit got;
    int first;
    sw = '1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (data[17:0] == 18'h3FFFF) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL sw_settle: got %h want %h", data[17:0], 18'h3FFFF); end
    @(posedge clk); #3; rst_n = 1'b0; #1;
    total++; if (data !== 32'h0) begin bad++; $display("FAIL async_reset: got %h want %h", data, 32'h0); end
    repeat (2) step();
    @(negedge clk); rst_n = 1'b1;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first < 0 && data[17:0] == 18'h3FFFF) first = k;
    end
    total++;
    if (first < 12 || first > 14) begin
      bad++; $display("FAIL sw_latency: got %0d cycles want 12..14", first);
    end
  endtask

  task automatic test_glitch();
    sw = '0;
    repeat (20) step();
    total++; if (data[17:0] !== 18'h0) begin bad++; $display("FAIL sw_low: got %h want %h", data[17:0], 18'h0); end
    sw[5] = 1'b1;
    for (int i = 0; i < 36; i++) begin
      if (i == 6) sw[5] = 1'b0;
      step();
      total++; if (data[5] !== 1'b0) begin bad++; $display("FAIL glitch_bit5 cyc %0d: got %b want 0", i, data[5]); end
    end
  endtask

  task automatic test_press();
    logic [BTN_W-1:0] seen, want;
    bit got;
    btn = 4'b1110;
    exp_q.push_back(4'b0001);
    wait_pulse(40, seen, got);
    want = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL press_timeout: got %h want %h", seen, want); end
    total++; if (seen !== want) begin bad++; $display("FAIL press_mask: got %h want %h", seen, want); end
    total++; if (data[24] !== 1'b1) begin bad++; $display("FAIL press_flag: got %b want 1", data[24]); end
    total++; if (data[20] !== 1'b1) begin bad++; $display("FAIL press_level: got %b want 1", data[20]); end
    step();
    total++; if (press !== 4'h0) begin bad++; $display("FAIL press_one_cycle: got %h want %h", press, 4'h0); end
    total++; if (data[24] !== 1'b1) begin bad++; $display("FAIL flag_sticky: got %b want 1", data[24]); end
  endtask

  task automatic test_flag_clear();
    clr = 4'b0001;
    step();
    clr = '0;
    total++; if (data[24] !== 1'b0) begin bad++; $display("FAIL flag_clear: got %b want 0", data[24]); end
    total++; if (data[20] !== 1'b1) begin bad++; $display("FAIL level_after_clear: got %b want 1", data[20]); end
    clr = 4'b0001;
    step();
    clr = '0;
    step();
    total++; if (data[24] !== 1'b0) begin bad++; $display("FAIL clear_idle_flag: got %b want 0", data[24]); end
  endtask

  task automatic test_collision();
    logic [BTN_W-1:0] seen, want;
    bit got;
    clr = 4'b0010;
    btn = 4'b1100;
    exp_q.push_back(4'b0010);
    wait_pulse(40, seen, got);
    want = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL coll_timeout: got %h want %h", seen, want); end
    total++; if (seen !== want) begin bad++; $display("FAIL coll_mask: got %h want %h", seen, want); end
    total++; if (data[25] !== 1'b1) begin bad++; $display("FAIL coll_set_wins: got %b want 1", data[25]); end
    step();
    total++; if (data[25] !== 1'b0) begin bad++; $display("FAIL coll_then_clear: got %b want 0", data[25]); end
    total++; if (press !== 4'h0) begin bad++; $display("FAIL coll_one_cycle: got %h want %h", press, 4'h0); end
    clr = '0;
  endtask

  task automatic test_bouncy();
    logic [BTN_W-1:0] seen, want;
    int pulses;
    pulses = 0;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn[3] = ~btn[3];
      step();
      if (press != '0) begin pulses++; seen = press; end
    end
    btn[3] = 1'b0;
    exp_q.push_back(4'b1000);
    for (int i = 0; i < 60; i++) begin
      step();
      if (press != '0) begin pulses++; seen = press; end
    end
    want = exp_q.pop_front();
    total++; if (pulses != 1) begin bad++; $display("FAIL bouncy_count: got %0d want 1", pulses); end
    total++; if (seen !== want) begin bad++; $display("FAIL bouncy_mask: got %h want %h", seen, want); end
    total++; if (data[27] !== 1'b1) begin bad++; $display("FAIL bouncy_flag: got %b want 1", data[27]); end
  endtask

  task automatic test_back_to_back();
    logic [BTN_W-1:0] seen, want;
    bit got;
    int pulses;
    for (int r = 0; r < 2; r++) begin
      btn[0] = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
        step();
        if (press[0]) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL release_pulse r%0d: got %0d want 0", r, pulses); end
      total++; if (data[20] !== 1'b0) begin bad++; $display("FAIL release_level r%0d: got %b want 0", r, data[20]); end
      btn[0] = 1'b0;
      exp_q.push_back(4'b0001);
      wait_pulse(40, seen, got);
      want = exp_q.pop_front();
      total++; if (!got || seen !== want) begin bad++; $display("FAIL repress_mask r%0d: got %h want %h", r, seen, want); end
      total++; if (data[24] !== 1'b1) begin bad++; $display("FAIL repress_flag r%0d: got %b want 1", r, data[24]); end
    end
  endtask

  task automatic test_held_through_reset();
    logic [BTN_W-1:0] seen, want;
    bit got;
    @(posedge clk); #3; rst_n = 1'b0; #1;
    total++; if (data !== 32'h0) begin bad++; $display("FAIL held_reset_data: got %h want %h", data, 32'h0); end
    repeat (2) step();
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(~btn);
    wait_pulse(40, seen, got);
    want = exp_q.pop_front();
    total++; if (!got || seen !== want) begin bad++; $display("FAIL held_requalify: got %h want %h", seen, want); end
    total++; if (data[27:24] !== want) begin bad++; $display("FAIL held_flags: got %h want %h", data[27:24], want); end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_glitch();
    test_press();
    test_flag_clear();
    test_collision();
    test_bouncy();
    test_back_to_back();
    test_held_through_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
